// File: rtl/register.sv
// Small register file used as scratch storage in the accelerator datapath.
// DEPTH entries of DATA_WIDTH bits, one write port and one read port.
// Read data is registered (one cycle latency) and held while r_en is low.
// A read and write to the same address in one cycle returns the new data.
// DEPTH must equal 2**ADDR_WIDTH so every address maps to a real entry.
module register #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_adr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] r_adr,
    output logic [DATA_WIDTH-1:0] r_data
);

    // Storage entries; reset clears every one, so they are kept as flops.
    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    logic [DATA_WIDTH-1:0] r_data_reg;
    logic [DATA_WIDTH-1:0] r_data_next;
    logic                  collision;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Each entry clears on reset and loads w_data when addressed by an enabled write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (w_en && (w_adr == ADDR_WIDTH'(gi))) begin
                    mem_reg[gi] <= w_data;
                end
            end
        end
    endgenerate

    // Same-address read and write in one cycle: forward the incoming data.
    assign collision = w_en && r_en && (w_adr == r_adr);

    // Select the next read value; hold the previous one when no read is requested.
    always_comb begin
        r_data_next = r_data_reg;
        if (r_en) begin
            if (collision) begin
                r_data_next = w_data;
            end else begin
                r_data_next = mem_reg[r_adr];
            end
        end
    end

    // Read data register; reset overrides any read requested in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_reg <= '0;
        end else begin
            r_data_reg <= r_data_next;
        end
    end

    assign r_data = r_data_reg;

endmodule

// File: tb/tb_register.sv
// Self-checking bench for the register file: a driver issues one operation
// per cycle and queues the expected r_data; a monitor compares after each edge.
module tb_register;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          w_en = 1'b0;
    logic [AW-1:0] w_adr = '0;
    logic [DW-1:0] w_data = '0;
    logic          r_en = 1'b0;
    logic [AW-1:0] r_adr = '0;
    logic [DW-1:0] r_data;

    typedef struct {
        string   name;
        logic [DW-1:0] exp;
    } txn_t;

    txn_t scoreboard[$];

    // Behavioural model of the storage contents and the visible read value.
    logic [DW-1:0] model_mem [N];
    logic [DW-1:0] model_rd;

    int checks = 0;
    int failures = 0;
    bit stim_done = 1'b0;

    register #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .w_en(w_en),
        .w_adr(w_adr),
        .w_data(w_data),
        .r_en(r_en),
        .r_adr(r_adr),
        .r_data(r_data)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue the r_data expected after the next edge.
    task automatic op(input string name, input bit rs, input bit we, input int wa,
                      input int wd, input bit re, input int ra);
        txn_t t;
        logic [DW-1:0] rd_val;
        @(negedge clk);
        rst    = rs;
        w_en   = we;
        w_adr  = AW'(wa);
        w_data = DW'(wd);
        r_en   = re;
        r_adr  = AW'(ra);
        if (rs) begin
            for (int i = 0; i < N; i++) model_mem[i] = '0;
            model_rd = '0;
        end else begin
            // Read sees the write when both target the same entry this cycle.
            if (re) begin
                rd_val = (we && wa == ra) ? DW'(wd) : model_mem[ra];
                model_rd = rd_val;
            end
            if (we) model_mem[wa] = DW'(wd);
        end
        t.name = name;
        t.exp  = model_rd;
        scoreboard.push_back(t);
    endtask

    // Monitor: one comparison per completed cycle, sampled just after the edge.
    initial begin
        txn_t t;
        forever begin
            @(posedge clk);
            #1;
            if (scoreboard.size() != 0) begin
                t = scoreboard.pop_front();
                checks++;
                if (r_data !== t.exp) begin
                    failures++;
                    $display("FAIL %s: r_data=%02h expected=%02h", t.name, r_data, t.exp);
                end else begin
                    $display("txn %s: r_data=%02h ok", t.name, r_data);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) model_mem[i] = 'x;
        model_rd = 'x;

        // Reset then read every entry.
        op("reset0", 1, 0, 0, 0, 0, 0);
        op("reset1", 1, 1, 1, 8'h33, 1, 1);
        for (int a = 0; a < N; a++) op($sformatf("rd_after_reset_%0d", a), 0, 0, 0, 0, 1, a);

        // Fill and read back.
        op("wr0", 0, 1, 0, 8'h8E, 0, 0);
        op("wr1", 0, 1, 1, 8'h86, 0, 0);
        op("wr2", 0, 1, 2, 8'h8C, 0, 0);
        op("wr3", 0, 1, 3, 8'hBE, 0, 0);
        op("rd2", 0, 0, 0, 0, 1, 2);
        op("rd3", 0, 0, 0, 0, 1, 3);

        // Hold: no read while entry 3 is overwritten.
        op("hold_wr3", 0, 1, 3, 8'h11, 0, 3);
        op("hold_idle", 0, 0, 0, 0, 0, 0);
        op("rd0", 0, 0, 0, 0, 1, 0);
        op("rd1", 0, 0, 0, 0, 1, 1);
        op("rd3_new", 0, 0, 0, 0, 1, 3);

        // Collision bypass, then confirm the entry was written.
        op("collide1", 0, 1, 1, 8'h5A, 1, 1);
        op("rd1_after_collide", 0, 0, 0, 0, 1, 1);
        op("diff_addr_rw", 0, 1, 2, 8'hC3, 1, 0);
        op("rd2_after_diff", 0, 0, 0, 0, 1, 2);

        // Disabled write must not alter entry 0.
        op("wr_disabled", 0, 0, 0, 8'hFF, 0, 0);
        op("rd0_after_disabled", 0, 0, 0, 0, 1, 0);

        // Reset mid-operation discards the concurrent write and read.
        op("reset_mid", 1, 1, 2, 8'h77, 1, 2);
        op("rd2_after_reset", 0, 0, 0, 0, 1, 2);
        op("rd0_after_reset", 0, 0, 0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            op($sformatf("rand_%0d", i),
               ($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 1)),
               int'($urandom_range(0, N - 1)),
               int'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)),
               int'($urandom_range(0, N - 1)));
        end
        op("final_idle", 0, 0, 0, 0, 0, 0);
        stim_done = 1'b1;

        // Bounded drain of outstanding expectations.
        for (int c = 0; c < 10 && scoreboard.size() != 0; c++) @(posedge clk);
        #2;
        checks++;
        if (scoreboard.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", scoreboard.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
